// File: rtl/dffram_2p_clr.sv
// Flop-based two-port RAM: registered read port 0, byte-masked write port 1,
// and a clear engine that sweeps every word to zero on request.
module dffram_2p_clr #(
  parameter  int WORDS = 512,
  parameter  int WSIZE = 4,
  localparam int AW    = $clog2(WORDS),
  localparam int DW    = 8 * WSIZE
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN0,
  input  logic [AW-1:0]    A0,
  output logic [DW-1:0]    Do0,
  input  logic             EN1,
  input  logic [WSIZE-1:0] WE1,
  input  logic [AW-1:0]    A1,
  input  logic [DW-1:0]    Di1,
  input  logic             CLR_REQ,
  output logic             CLR_BUSY,
  output logic             CLR_DONE
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  // WORDS need not be a power of two, so addresses above the top word exist
  localparam logic [AW:0]   LIM  = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_do;
  logic [AW-1:0] r_cnt;
  state_t        r_state;
  logic          r_busy;
  logic          r_done;

  logic          w_a0_ok;
  logic          w_a1_ok;
  logic          w_sweep;
  logic          w_wr;
  logic [DW-1:0] w_rdata;

  assign w_a0_ok = ({1'b0, A0} < LIM);
  assign w_a1_ok = ({1'b0, A1} < LIM);
  assign w_sweep = (r_state == S_SWEEP);
  // Writes are locked out for the whole sweep so nothing survives the wipe
  assign w_wr    = EN1 && w_a1_ok && !w_sweep;

  // Read mux: array word, with write-first bypass on lanes being written
  always_comb begin
    w_rdata = '0;
    if (w_a0_ok) w_rdata = r_mem[A0];
    for (int i = 0; i < WSIZE; i++) begin
      if (w_wr && WE1[i] && (A0 == A1)) w_rdata[8*i +: 8] = Di1[8*i +: 8];
    end
  end

  // Array storage: sweep clear has priority over port-1 byte writes; no reset
  always_ff @(posedge CLK) begin
    if (w_sweep) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < WSIZE; i++) begin
        if (WE1[i]) r_mem[A1][8*i +: 8] <= Di1[8*i +: 8];
      end
    end
  end

  // Registered read data; reads during a sweep return zero so stale data never leaks
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_do <= '0;
    end else if (EN0) begin
      r_do <= w_sweep ? '0 : w_rdata;
    end
  end

  // Clear FSM: IDLE -> SWEEP (WORDS cycles) -> DONE (one cycle) -> IDLE
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (CLR_REQ) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          // Counter stops at the last word; it never walks past WORDS-1
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Do0      = r_do;
  assign CLR_BUSY = r_busy;
  assign CLR_DONE = r_done;

endmodule

// File: tb/tb_dffram_2p_clr.sv
// Directed bench for dffram_2p_clr: a 512-word instance for the main checks and
// a 300-word instance for the non-power-of-two address boundary.
module tb_dffram_2p_clr;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 512-word instance
  logic        RSTn, EN0, EN1, CLR_REQ, CLR_BUSY, CLR_DONE;
  logic [8:0]  A0, A1;
  logic [3:0]  WE1;
  logic [31:0] Di1, Do0;
  // 300-word instance
  logic        RSTn_b, EN0_b, EN1_b, CLR_REQ_b, CLR_BUSY_b, CLR_DONE_b;
  logic [8:0]  A0_b, A1_b;
  logic [3:0]  WE1_b;
  logic [31:0] Di1_b, Do0_b;

  dffram_2p_clr u_dut (
    .CLK(CLK), .RSTn(RSTn), .EN0(EN0), .A0(A0), .Do0(Do0), .EN1(EN1), .WE1(WE1),
    .A1(A1), .Di1(Di1), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE)
  );

  dffram_2p_clr #(.WORDS(300)) u_dut300 (
    .CLK(CLK), .RSTn(RSTn_b), .EN0(EN0_b), .A0(A0_b), .Do0(Do0_b), .EN1(EN1_b),
    .WE1(WE1_b), .A1(A1_b), .Di1(Di1_b), .CLR_REQ(CLR_REQ_b), .CLR_BUSY(CLR_BUSY_b),
    .CLR_DONE(CLR_DONE_b)
  );

  typedef struct {
    logic [31:0] d;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m [512];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          busy_cyc;
  int          done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input string tag);
    exp_t e;
    e.d   = d;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = q.pop_front();
      chk(e.tag, obs, e.d);
    end
  endtask

  // One clock: drive at negedge, let the posedge act, sample 1 time unit later
  task automatic step(input bit sel, input logic en0, input logic [8:0] a0,
                      input logic en1, input logic [3:0] we, input logic [8:0] a1,
                      input logic [31:0] d, input logic req);
    @(negedge CLK);
    EN0 = 1'b0; EN1 = 1'b0; CLR_REQ = 1'b0; EN0_b = 1'b0; EN1_b = 1'b0; CLR_REQ_b = 1'b0;
    if (!sel) begin
      EN0 = en0; A0 = a0; EN1 = en1; WE1 = we; A1 = a1; Di1 = d; CLR_REQ = req;
    end else begin
      EN0_b = en0; A0_b = a0; EN1_b = en1; WE1_b = we; A1_b = a1; Di1_b = d; CLR_REQ_b = req;
    end
    @(posedge CLK);
    #1;
    if (CLR_DONE === 1'b1) done_seen++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] we);
    step(0, 0, 0, 1, we, 9'(a), d, 0);
    for (int i = 0; i < 4; i++) if (we[i]) m[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic rd(input int a, input string tag);
    push(m[a], tag);
    step(0, 1, 9'(a), 0, 0, 0, 0, 0);
    pop_chk(Do0);
  endtask

  initial begin
    RSTn = 1'b0; EN0 = 1'b0; EN1 = 1'b0; CLR_REQ = 1'b0; A0 = '0; A1 = '0; WE1 = '0; Di1 = '0;
    RSTn_b = 1'b0; EN0_b = 1'b0; EN1_b = 1'b0; CLR_REQ_b = 1'b0; A0_b = '0; A1_b = '0;
    WE1_b = '0; Di1_b = '0;
    done_seen = 0;
    #12;
    chk("rst_do0", Do0, 32'h0);
    chk("rst_busy", {31'b0, CLR_BUSY}, 32'h0);
    chk("rst_done", {31'b0, CLR_DONE}, 32'h0);
    @(negedge CLK);
    RSTn = 1'b1; RSTn_b = 1'b1;

    // Full-word write then read back
    wr(5, 32'hDEADBEEF, 4'hF);
    rd(5, "t1_rd5");
    // EN0 low holds the previous read data
    idle();
    chk("hold_en0_low", Do0, 32'hDEADBEEF);

    // Byte-masked write with same-cycle read of the same word
    wr(7, 32'h11223344, 4'hF);
    push(32'h11BB33DD, "t2_same_cycle");
    step(0, 1, 9'd7, 1, 4'b0101, 9'd7, 32'hAABBCCDD, 0);
    pop_chk(Do0);
    m[7] = 32'h11BB33DD;
    rd(7, "t2_later");

    // Fill every word with its address, then sweep with traffic during it
    for (int a = 0; a < 512; a++) wr(a, 32'(a), 4'hF);
    rd(10, "t3_pre10");
    step(0, 0, 0, 0, 0, 0, 0, 1);
    busy_cyc  = 0;
    done_seen = 0;
    while (CLR_BUSY === 1'b1 && busy_cyc < 1000) begin
      busy_cyc++;
      if (busy_cyc == 5) begin
        step(0, 0, 0, 1, 4'hF, 9'd3, 32'h55, 0);
      end else if (busy_cyc == 10) begin
        push(32'h0, "t4_sweep_rd10");
        step(0, 1, 9'd10, 0, 0, 0, 0, 0);
        pop_chk(Do0);
      end else if (busy_cyc == 50) begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        idle();
      end
    end
    chk("t3_busy_cycles", 32'(busy_cyc), 32'd512);
    chk("t3_done_early", 32'(done_seen), 32'd1);
    chk("t3_done_pulse", {31'b0, CLR_DONE}, 32'h1);
    idle();
    chk("t3_done_one_cycle", {31'b0, CLR_DONE}, 32'h0);
    chk("t3_busy_idle", {31'b0, CLR_BUSY}, 32'h0);
    for (int a = 0; a < 512; a++) m[a] = 32'h0;
    rd(3, "t4_mem3_dropped");
    for (int a = 0; a < 512; a++) rd(a, "t3_cleared");

    // Reset in the middle of a sweep
    for (int a = 0; a < 256; a++) wr(a, 32'hA5A50000 | 32'(a), 4'hF);
    rd(200, "t5_pre200");
    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (100) idle();
    chk("t5_busy_mid", {31'b0, CLR_BUSY}, 32'h1);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("t5_rst_do0", Do0, 32'h0);
    chk("t5_rst_busy", {31'b0, CLR_BUSY}, 32'h0);
    chk("t5_rst_done", {31'b0, CLR_DONE}, 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    done_seen = 0;
    repeat (4) idle();
    chk("t5_no_done", 32'(done_seen), 32'd0);
    chk("t5_busy_after", {31'b0, CLR_BUSY}, 32'h0);
    for (int a = 0; a < 100; a++) m[a] = 32'h0;
    for (int a = 0; a < 100; a++) rd(a, "t5_cleared");
    rd(100, "t5_w100_kept");
    rd(200, "t5_w200_kept");

    // Non-power-of-two depth: top word valid, out-of-range address dropped
    step(1, 0, 0, 1, 4'hF, 9'd299, 32'h12345678, 0);
    step(1, 0, 0, 1, 4'hF, 9'd54, 32'hCAFEF00D, 0);
    step(1, 0, 0, 1, 4'hF, 9'd310, 32'hFFFFFFFF, 0);
    push(32'h12345678, "t6_rd299");
    step(1, 1, 9'd299, 0, 0, 0, 0, 0);
    pop_chk(Do0_b);
    push(32'h0, "t6_rd310");
    step(1, 1, 9'd310, 0, 0, 0, 0, 0);
    pop_chk(Do0_b);
    push(32'hCAFEF00D, "t6_rd54");
    step(1, 1, 9'd54, 0, 0, 0, 0, 0);
    pop_chk(Do0_b);
    push(32'h0, "t6_rd310_samecyc");
    step(1, 1, 9'd310, 1, 4'hF, 9'd310, 32'h0BADF00D, 0);
    pop_chk(Do0_b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
